// File: rtl/dac_pkg.sv
// Shared types and widths for the DAC command sequencer.
// Frame layout is {comm, addr, data}, 24 bits, matching the serial driver's command word.
package dac_pkg;

  localparam int CMD_W   = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } seq_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  comm;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dac_cmd_t;

endpackage

// File: rtl/dac_cmd_sequencer_if.sv
// Host command handshake into the sequencer (valid/ready, one frame per beat).
// master = command decoder side, slave = sequencer side.
interface dac_cmd_sequencer_if;
  import dac_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_comm;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_comm, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_comm, cmd_addr, cmd_data, output cmd_ready);

endinterface

// File: rtl/dac_cmd_fifo.sv
// Synchronous DEPTH x FRAME_W command FIFO; head is visible combinationally, pop takes effect at the edge.
// full is registered from next-cycle occupancy; push while full and pop while empty are ignored.
module dac_cmd_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  dac_cmd_t push_dat,
  input  logic     pop,
  output dac_cmd_t head,
  output logic     full,
  output logic     empty,
  output logic [AW:0] level
);

  dac_cmd_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level_nxt;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (do_pop && !do_push)
      level_nxt = level - 1'b1;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dac_cmd_sequencer.sv
// Queues host DAC frames and launches them one at a time (ext_ctrl 2 cycles after a push into an idle, empty queue).
// cmd_ready drops while the FIFO is full; optional shadow register file under DAC_SHADOW_EN.
module dac_cmd_sequencer
  import dac_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int START_TMO = 64,
  parameter int GAP_CYC   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dac_cmd_sequencer_if.slave      host,
  input  logic                    dac_init_done,
  input  logic                    dac_busy,
  output logic [CMD_W-1:0]        comm,
  output logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       data,
  output logic                    ext_ctrl,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic                    tmo,
  input  logic                    err_clr,
  output logic [15:0]             issued_cnt
`ifdef DAC_SHADOW_EN
  ,
  input  logic [3:0]              shadow_raddr,
  output logic [15:0]             shadow_rdata
`endif
);

  localparam int CNT_MAX = (START_TMO > GAP_CYC) ? START_TMO : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TMO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  dac_cmd_t          cur;
  dac_cmd_t          head;
  dac_cmd_t          push_dat;
  logic              rdy_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              ovf_evt;
  logic              pop;
  logic              launch;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              done;
  logic              tmo_evt;

  // rdy_en keeps cmd_ready low throughout reset and for the reset edge itself.
  assign host.cmd_ready = rdy_en & ~fifo_full;
  assign push           = host.cmd_valid & host.cmd_ready;
  assign ovf_evt        = host.cmd_valid & fifo_full;
  assign push_dat       = {host.cmd_comm, host.cmd_addr, host.cmd_data};

  assign comm = cur.comm;
  assign addr = cur.addr;
  assign data = cur.data;

  dac_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    launch    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    done      = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && dac_init_done && !dac_busy) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        launch    = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dac_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          tmo_evt   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = GAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!dac_busy) begin
          done      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
        else                 cnt_inc   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur        <= '0;
      ext_ctrl   <= 1'b0;
      rdy_en     <= 1'b0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
      issued_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rdy_en   <= 1'b1;
      ext_ctrl <= launch;
      if (pop)          cur <= head;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (done)         issued_cnt <= issued_cnt + 16'd1;
      // A fresh overflow beats err_clr; a fresh timeout does not.
      if (ovf_evt)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (err_clr)      tmo <= 1'b0;
      else if (tmo_evt) tmo <= 1'b1;
    end
  end

`ifdef DAC_SHADOW_EN
  logic [15:0] shadow_mem [16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow_mem[i] <= '0;
      shadow_rdata <= '0;
    end else begin
      if (done) shadow_mem[cur.addr] <= cur.data;
      shadow_rdata <= shadow_mem[shadow_raddr];
    end
  end
`endif

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// Directed bench: queued frames are checked by a launch monitor that also models the DAC driver's busy pulse.
module tb_dac_cmd_sequencer;
  import dac_pkg::*;

  localparam int DEPTH     = 8;
  localparam int START_TMO = 64;
  localparam int GAP_CYC   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dac_init_done;
  logic        dac_busy;
  logic        err_clr;
  logic [3:0]  comm;
  logic [3:0]  addr;
  logic [15:0] data;
  logic        ext_ctrl;
  logic [3:0]  level;
  logic        ovf;
  logic        tmo;
  logic [15:0] issued_cnt;
`ifdef DAC_SHADOW_EN
  logic [3:0]  shadow_raddr;
  logic [15:0] shadow_rdata;
`endif

  dac_cmd_sequencer_if hif ();

  dac_cmd_sequencer #(.DEPTH(DEPTH), .START_TMO(START_TMO), .GAP_CYC(GAP_CYC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (hif),
    .dac_init_done (dac_init_done),
    .dac_busy      (dac_busy),
    .comm          (comm),
    .addr          (addr),
    .data          (data),
    .ext_ctrl      (ext_ctrl),
    .level         (level),
    .ovf           (ovf),
    .tmo           (tmo),
    .err_clr       (err_clr),
    .issued_cnt    (issued_cnt)
`ifdef DAC_SHADOW_EN
    ,
    .shadow_raddr  (shadow_raddr),
    .shadow_rdata  (shadow_rdata)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];
  int          cyc       = 0;
  int          fall_cyc  = -100;
  bit          drv_respond = 1'b1;
  int          busy_len  = 5;
  int          busy_left = 0;
  int          exp_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    hif.cmd_comm  = c;
    hif.cmd_addr  = a;
    hif.cmd_data  = d;
    hif.cmd_valid = 1'b1;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic wait_launch();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ext_ctrl) begin
        seen = 1'b1;
        break;
      end
    end
    chk("launch_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_issued();
    for (int i = 0; i < 300 && issued_cnt != 16'(exp_issued); i++) @(negedge clk);
    chk("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
  endtask

  // Launch monitor + driver model: every ext_ctrl pulse must match the queue head.
  initial begin
    logic [23:0] e;
    dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          dac_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (ext_ctrl) begin
        chk("launch_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("launch_frame", {8'h0, comm, addr, data}, {8'h0, e});
        end
        chk("launch_gap", 32'((cyc - fall_cyc) >= GAP_CYC + 3), 32'd1);
        if (drv_respond) begin
          dac_busy  = 1'b1;
          busy_left = busy_len;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.cmd_comm  = '0;
    hif.cmd_addr  = '0;
    hif.cmd_data  = '0;
    dac_init_done = 1'b1;
    err_clr       = 1'b0;
`ifdef DAC_SHADOW_EN
    shadow_raddr  = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(hif.cmd_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(hif.cmd_ready), 32'd1);
    chk("post_rst_frame", {8'h0, comm, addr, data}, 32'd0);
    chk("post_rst_flags", {29'd0, ext_ctrl, ovf, tmo}, 32'd0);
    chk("post_rst_issued", 32'(issued_cnt), 32'd0);

    // 1: single frame, launch latency
    exp_q.push_back({4'd3, 4'd1, 16'h8000});
    push(4'd3, 4'd1, 16'h8000);
    chk("lat_ext_k1", 32'(ext_ctrl), 32'd0);
    @(negedge clk);
    chk("lat_ext_k2", 32'(ext_ctrl), 32'd0);
    @(negedge clk);
    chk("lat_ext_k3", 32'(ext_ctrl), 32'd1);
    @(negedge clk);
    chk("lat_ext_single", 32'(ext_ctrl), 32'd0);
    exp_issued = 1;
    wait_issued();

    // 2: blocked by init_done, then FIFO-order drain
    dac_init_done = 1'b0;
    exp_q.push_back({4'd1, 4'd2, 16'h0011}); push(4'd1, 4'd2, 16'h0011);
    exp_q.push_back({4'd2, 4'd3, 16'h0022}); push(4'd2, 4'd3, 16'h0022);
    exp_q.push_back({4'd4, 4'd5, 16'h0033}); push(4'd4, 4'd5, 16'h0033);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ext_ctrl) n++;
    end
    chk("blocked_launches", 32'(n), 32'd0);
    chk("blocked_level", 32'(level), 32'd3);
    dac_init_done = 1'b1;
    repeat (3) wait_launch();
    exp_issued += 3;
    wait_issued();

    // 3: fill, overflow, err_clr
    dac_init_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({4'(i), 4'(15 - i), 16'(16'hA000 + i)});
      push(4'(i), 4'(15 - i), 16'(16'hA000 + i));
      if (i == 6) chk("ready_at_7", 32'(hif.cmd_ready), 32'd1);
    end
    chk("ready_full", 32'(hif.cmd_ready), 32'd0);
    chk("level_full", 32'(level), 32'd8);
    push(4'hF, 4'hF, 16'hDEAD);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("level_after_ovf", 32'(level), 32'd8);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    err_clr = 1'b1;
    push(4'hE, 4'hE, 16'hBEEF);
    err_clr = 1'b0;
    chk("ovf_set_beats_clr", 32'(ovf), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 32'd0);
    dac_init_done = 1'b1;
    repeat (8) wait_launch();
    exp_issued += 8;
    wait_issued();

    // 4: start timeout, then next command proceeds
    drv_respond = 1'b0;
    exp_q.push_back({4'd7, 4'd7, 16'h7777}); push(4'd7, 4'd7, 16'h7777);
    exp_q.push_back({4'd8, 4'd8, 16'h8888}); push(4'd8, 4'd8, 16'h8888);
    wait_launch();
    repeat (START_TMO - 1) @(negedge clk);
    chk("tmo_before", 32'(tmo), 32'd0);
    @(negedge clk);
    chk("tmo_set", 32'(tmo), 32'd1);
    chk("tmo_issued_unch", 32'(issued_cnt), 32'(exp_issued));
    drv_respond = 1'b1;
    wait_launch();
    exp_issued += 1;
    wait_issued();
    chk("tmo_sticky", 32'(tmo), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("tmo_clr", 32'(tmo), 32'd0);

    // 5: reset during WAIT_DONE with 4 queued
    busy_len = 20;
    exp_q.push_back({4'd5, 4'd6, 16'h5656}); push(4'd5, 4'd6, 16'h5656);
    wait_launch();
    for (int i = 0; i < 4; i++) push(4'd9, 4'(i), 16'(16'h9000 + i));
    chk("level_in_flight", 32'(level), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_frame", {8'h0, comm, addr, data}, 32'd0);
    chk("midrst_flags", {29'd0, ext_ctrl, ovf, tmo}, 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_issued", 32'(issued_cnt), 32'd0);
    chk("midrst_ready", 32'(hif.cmd_ready), 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ext_ctrl) n++;
    end
    chk("no_launch_after_rst", 32'(n), 32'd0);
    chk("issued_after_rst", 32'(issued_cnt), 32'd0);
    exp_issued = 0;
    busy_len = 5;

`ifdef DAC_SHADOW_EN
    // 6: shadow register file
    exp_q.push_back({4'd3, 4'd2, 16'h1234}); push(4'd3, 4'd2, 16'h1234);
    exp_q.push_back({4'd3, 4'd2, 16'hABCD}); push(4'd3, 4'd2, 16'hABCD);
    exp_issued = 2;
    wait_issued();
    shadow_raddr = 4'd2;
    @(negedge clk);
    chk("shadow_addr2", 32'(shadow_rdata), 32'h0000ABCD);
    shadow_raddr = 4'd5;
    @(negedge clk);
    chk("shadow_addr5", 32'(shadow_rdata), 32'd0);
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
